// File: rtl/fifo_selfadd_engine_pkg.sv
// Shared definitions for the FIFO self-add engine: opcodes, FSM states
// and the location of the opcode/payload fields inside a command word.
package fifo_selfadd_engine_pkg;

  localparam int OP_W = 2;

  typedef enum logic [1:0] {
    OP_DBL  = 2'b00,
    OP_ACC  = 2'b01,
    OP_EMIT = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    EXEC    = 2'b10,
    PUSH    = 2'b11
  } state_e;

  // Opcode sits in the top OP_W bits; payload fills everything below it.
  function automatic int op_msb(input int w);
    return w - 1;
  endfunction

  function automatic int op_lsb(input int w);
    return w - OP_W;
  endfunction

  function automatic int pay_msb(input int w);
    return w - OP_W - 1;
  endfunction

endpackage

// File: rtl/fifo_selfadd_engine_if.sv
// FIFO-facing bus of the engine: pop side of the host-to-user FIFO and
// push side of the user-to-host FIFO.
interface fifo_selfadd_engine_if
  import fifo_selfadd_engine_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              data_empty;
  logic              data_rd;
  logic [DATA_W-1:0] data_din;
  logic              data_full;
  logic              data_wr;
  logic [DATA_W-1:0] data_dout;

  // Engine side.
  modport master (
    input  data_empty,
    output data_rd,
    input  data_din,
    input  data_full,
    output data_wr,
    output data_dout
  );

  // FIFO side.
  modport slave (
    output data_empty,
    input  data_rd,
    output data_din,
    output data_full,
    input  data_wr,
    input  data_dout
  );

endinterface

// File: rtl/fifo_selfadd_alu.sv
// Combinational opcode datapath: computes the output word, the next
// accumulator value, the accumulator carry-out and whether a push is due.
module fifo_selfadd_alu
  import fifo_selfadd_engine_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] pay_i,
  input  logic [DATA_W-1:0] acc_i,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] next_acc_o,
  output logic              carry_o,
  output logic              emit_o
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, acc_i} + {1'b0, pay_i};

  // Opcode decode; the payload is narrower than the word, so doubling
  // it can never overflow.
  always_comb begin
    result_o   = '0;
    next_acc_o = acc_i;
    carry_o    = 1'b0;
    emit_o     = 1'b0;
    case (op_i)
      OP_DBL: begin
        result_o = pay_i + pay_i;
        emit_o   = 1'b1;
      end
      OP_ACC: begin
        next_acc_o = sum[DATA_W-1:0];
        carry_o    = sum[DATA_W];
      end
      OP_EMIT: begin
        result_o   = acc_i;
        next_acc_o = '0;
        emit_o     = 1'b1;
      end
      OP_CLR: begin
        next_acc_o = '0;
      end
      default: begin
        next_acc_o = acc_i;
      end
    endcase
  end

endmodule

// File: rtl/fifo_selfadd_engine.sv
// Pops command words, runs them through the ALU and pushes results, one
// word in flight at a time, with backpressure from both FIFOs.
module fifo_selfadd_engine
  import fifo_selfadd_engine_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  fifo_selfadd_engine_if.master bus,
  output logic [DATA_W-1:0]     acc_q,
  output logic [CNT_W-1:0]      word_cnt,
  output logic                  ovf
);

  localparam int OP_MSB  = op_msb(DATA_W);
  localparam int OP_LSB  = op_lsb(DATA_W);
  localparam int PAY_MSB = pay_msb(DATA_W);
  localparam int WAIT_W  = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  op_e               op;
  logic [DATA_W-1:0] pay;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_next_acc;
  logic              alu_carry;
  logic              alu_emit;

  assign op  = op_e'(bus.data_din[OP_MSB:OP_LSB]);
  assign pay = {{OP_W{1'b0}}, bus.data_din[PAY_MSB:0]};

  fifo_selfadd_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i       (op),
    .pay_i      (pay),
    .acc_i      (acc_q),
    .result_o   (alu_result),
    .next_acc_o (alu_next_acc),
    .carry_o    (alu_carry),
    .emit_o     (alu_emit)
  );

  assign bus.data_rd   = rd_q;
  assign bus.data_wr   = wr_q;
  assign bus.data_dout = dout_q;
  assign word_cnt      = cnt_q;
  assign ovf           = ovf_q;

  // Next-state logic: pop only from IDLE, wait out the FIFO read latency,
  // execute once, then hold the result in PUSH until the output has room.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    dout_d  = dout_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (!bus.data_empty) begin
          rd_d    = 1'b1;
          wait_d  = WAIT_W'(RD_LAT);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_q <= WAIT_W'(1)) begin
          state_d = EXEC;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = alu_next_acc;
        if (op == OP_CLR) begin
          ovf_d = 1'b0;
        end else if (alu_carry) begin
          ovf_d = 1'b1;
        end
        if (alu_emit) begin
          dout_d  = alu_result;
          state_d = PUSH;
        end else begin
          state_d = IDLE;
        end
      end
      PUSH: begin
        if (!bus.data_full) begin
          wr_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/fifo_selfadd_engine.md
Name: fifo_selfadd_engine

Overview:
User-logic stage between the host-to-user FIFO and the user-to-host FIFO. Pops 32-bit command words from the host-to-user FIFO and decodes a 2-bit opcode in each word. Each word either doubles its payload, accumulates it into a running sum, emits the sum, or clears the sum. Results are pushed into the user-to-host FIFO, with full backpressure on both sides.

Parameters:
DATA_W, 32, FIFO word width; opcode is in bits [DATA_W-1:DATA_W-2], payload in the remaining low bits
RD_LAT, 1, cycles from a data_rd pulse until data_din is valid (matches the FIFO's registered read port)
CNT_W, 16, width of the consumed-word debug counter

Ports:
clock  in  1  single clock domain
reset  in  1  asynchronous, active-high
data_empty  in  1  input FIFO empty
data_rd  out  1  input FIFO pop, one-cycle pulse
data_din  in  DATA_W  input FIFO read data
data_full  in  1  output FIFO full
data_wr  out  1  output FIFO push, one-cycle pulse
data_dout  out  DATA_W  output FIFO write data, registered
acc_q  out  DATA_W  current accumulator (debug)
word_cnt  out  CNT_W  count of words consumed (debug)
ovf  out  1  sticky accumulator carry-out flag

Behaviour:
- Reset (asynchronous, active-high):
  - data_rd, data_wr, data_dout, acc_q, word_cnt and ovf all go to 0.
  - State goes to IDLE; any in-flight word is discarded.
- States: IDLE, RD_WAIT, EXEC, PUSH.
- IDLE:
  - If data_empty=0: assert data_rd for 1 cycle, load the wait counter with RD_LAT, go to RD_WAIT.
  - Otherwise stay in IDLE.
- RD_WAIT: count down RD_LAT cycles; data_rd=0; then go to EXEC.
- EXEC: sample data_din; op = din[31:30]; pay = {2'b0, din[29:0]}; word_cnt increments by 1 (wraps FFFF->0). Per opcode:
  - op=00: data_dout <= pay+pay; go to PUSH.
  - op=01: acc <= acc+pay (mod 2^32); a carry-out sets ovf=1 (sticky); go to IDLE.
  - op=10: data_dout <= acc; acc <= 0 in the same cycle (ovf unchanged); go to PUSH.
  - op=11: acc <= 0 and ovf <= 0; no output; go to IDLE.
- PUSH:
  - If data_full=0: assert data_wr for exactly 1 cycle, go to IDLE.
  - Otherwise hold data_dout and wait, with data_wr=0.
- No new pop is issued while in RD_WAIT, EXEC or PUSH. At most one word is in flight, so minimum spacing is 3 cycles for non-output ops and 4 cycles for output ops.
- data_dout holds its last pushed value until the next EXEC that produces output; it is never driven to 0 between pushes.
- data_full does not affect popping of non-output opcodes.
- data_empty is sampled only in IDLE. A word that arrives during PUSH is popped on the first IDLE cycle.
- Reset asserted mid-PUSH: no data_wr is produced, and the pending result is lost.
- acc_q mirrors the acc register directly.

Decomposition:
- Shared package holds:
  - opcode constants: OP_DBL=2'b00, OP_ACC=2'b01, OP_EMIT=2'b10, OP_CLR=2'b11
  - state encoding for IDLE/RD_WAIT/EXEC/PUSH
  - bit positions of the opcode and payload fields
- One combinational sub-module, fifo_selfadd_alu:
  - inputs: op, pay, acc
  - outputs: result, next_acc, carry, emit
- FSM, counters and the backpressure logic stay in fifo_selfadd_engine.

Test Plan:
1. data_din=0x0000_0005 presented with data_empty=0 -> exactly one data_rd pulse; 3 cycles later one data_wr with data_dout=0x0000_000A; word_cnt=1.
2. Words 0x4000_0003, 0x4000_0004, then 0x8000_0000 -> exactly one data_wr, with data_dout=0x0000_0007; acc_q=0 afterwards; word_cnt=3.
3. Five words 0x7FFF_FFFF (op01, pay=0x3FFF_FFFF) -> after the fourth, acc_q=0xFFFF_FFFC and ovf=0; after the fifth, acc_q=0x3FFF_FFFB and ovf=1. Then 0xC000_0000 -> acc_q=0 and ovf=0, with no data_wr.
4. data_full=1 while an op00 result for 0x0000_0010 is pending, and more words are queued -> data_wr=0 and no further data_rd for 20 cycles. Drop data_full -> exactly one data_wr with 0x0000_0020, then popping resumes.
5. data_empty held at 1 for 50 cycles -> data_rd never asserted; all outputs stay at their reset values.
6. reset asserted during PUSH, with data_full=1 and result 0x0000_0002 pending -> data_wr=0, data_dout=0, word_cnt=0, acc_q=0, state IDLE. After reset releases, processing restarts cleanly with the next word.
